pipeline_debug_ctrl: RTL and testbench
======================================

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

Interface
REQ-001 SHALL have ports Clock (in, 1, single clock) and Reset (in, 1); one clock domain, reset is synchronous and active-high.
REQ-002 SHALL have In_Byte (in, 8): command or program byte from the host receiver.
REQ-003 SHALL have In_Valid (in, 1) and In_Ready (out, 1): byte handshake; transfer occurs when both are high on a rising Clock edge.
REQ-004 SHALL have Halt_WB (in, 1): the halt instruction (0xFFFFFFFF) is in the WB stage.
REQ-005 SHALL have PipeEnable (out, 1): pipeline register and PC clock enable.
REQ-006 SHALL have PipeReset (out, 1): pipeline reset pulse.
REQ-007 SHALL have IMem_WrEn (out, 1), IMem_WrAddr (out, 8, word address) and IMem_WrData (out, 32): instruction memory write port.
REQ-008 SHALL have State_Out (out, 3): current state encoding.

Function
REQ-009 SHALL implement states IDLE=0, LOAD=1, RUN=2, STEP=3, DONE=4; no other encodings are reachable.
REQ-010 In IDLE, SHALL decode accepted bytes as commands: 0x4C 'L' -> LOAD, 0x43 'C' -> RUN, 0x53 'S' -> STEP, 0x52 'R' -> one-cycle PipeReset, stay IDLE. All other bytes are consumed and ignored.
REQ-011 On entry to LOAD, SHALL clear the byte counter and IMem_WrAddr to 0.
REQ-012 In LOAD, SHALL assemble each 4 accepted bytes into one word, big-endian (first byte to [31:24]).
REQ-013 In LOAD, SHALL pulse IMem_WrEn for exactly one cycle, on the cycle after the 4th byte is accepted, with the assembled word and current address; the address SHALL then increment by 1.
REQ-014 In LOAD, SHALL return to IDLE after writing word 0xFFFFFFFF, or after writing address 255 (no wrap), whichever comes first.
REQ-015 In RUN, SHALL hold PipeEnable high and In_Ready low.
REQ-016 In RUN, when Halt_WB is sampled high, SHALL drop PipeEnable on the next cycle and enter DONE.
REQ-017 In STEP, each accepted 'S' byte SHALL produce exactly one PipeEnable cycle, starting the cycle after acceptance.
REQ-018 In STEP, an accepted 'Q' (0x51) SHALL return to IDLE; other bytes are ignored.
REQ-019 If Halt_WB is high when a step completes, SHALL enter DONE, and any byte in flight SHALL be ignored.
REQ-020 In DONE, PipeEnable SHALL be 0; an accepted 'R' SHALL pulse PipeReset and go to IDLE; other bytes are ignored.
REQ-021 In_Ready SHALL be 1 in IDLE, LOAD, STEP and DONE, except during the IMem_WrEn cycle and the STEP enable cycle, when it SHALL be 0.
REQ-022 PipeReset SHALL be exactly one cycle wide and SHALL never coincide with PipeEnable.

Reset
REQ-023 Reset high SHALL force, on the next edge: state IDLE, PipeEnable=0, PipeReset=0, IMem_WrEn=0, IMem_WrAddr=0, IMem_WrData=0, byte counter=0, In_Ready=1.
REQ-024 Reset SHALL take priority over all inputs, including mid-LOAD; a partially assembled word SHALL be discarded and not written.

Configuration
REQ-025 With DEBUG_CYCLE_COUNT_EN defined, SHALL add output Cycle_Count (32). It increments on each PipeEnable cycle, clears on Reset and on PipeReset, and wraps modulo 2^32.
REQ-026 Without DEBUG_CYCLE_COUNT_EN, the Cycle_Count port and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-027 Send 'L', 00 00 00 20, 8C 01 00 04, FF FF FF FF -> three IMem_WrEn pulses at addr 0,1,2 with data 0x00000020, 0x8C010004, 0xFFFFFFFF; then State_Out=0.
REQ-028 Send 'C', Halt_WB high at cycle 10 -> PipeEnable high for 10 cycles then low, State_Out=4; with macro, Cycle_Count=10.
REQ-029 Send 'S', 'S', 'S', 'Q' -> exactly 3 single-cycle PipeEnable pulses, then State_Out=0.
REQ-030 Send 'L', 12 34, then assert Reset -> no IMem_WrEn, State_Out=0, IMem_WrAddr=0; a following load starts at addr 0.
REQ-031 Send 'L' followed by 256 non-halt words -> final write at addr 255, return to IDLE, no write to addr 0 afterwards.
REQ-032 From DONE, send 0x43 then 'R' -> 0x43 ignored, one PipeReset pulse, State_Out=0; with macro, Cycle_Count=0.

Source files
------------

// File: rtl/pipeline_debug_ctrl.sv
// rtl/pipeline_debug_ctrl.sv - host-driven load/run/step debug controller for a pipelined core
// Optional build macro: DEBUG_CYCLE_COUNT_EN adds the Cycle_Count output and its counter.
module pipeline_debug_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  In_Byte,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic        Halt_WB,
  output logic        PipeEnable,
  output logic        PipeReset,
  output logic        IMem_WrEn,
  output logic [7:0]  IMem_WrAddr,
  output logic [31:0] IMem_WrData,
  output logic [2:0]  State_Out
`ifdef DEBUG_CYCLE_COUNT_EN
  ,
  output logic [31:0] Cycle_Count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  CMD_RUN   = 8'h43;
  localparam logic [7:0]  CMD_STEP  = 8'h53;
  localparam logic [7:0]  CMD_RESET = 8'h52;
  localparam logic [7:0]  CMD_QUIT  = 8'h51;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [7:0]  LAST_ADDR = 8'hFF;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        pipe_en_q, pipe_en_d;
  logic        pipe_rst_q, pipe_rst_d;
  logic        in_ready_q, in_ready_d;
  logic        accept;

  assign accept = In_Valid && in_ready_q;

  // Next-state and next-output decode for the command/load/run/step FSM
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pipe_en_d  = 1'b0;
    pipe_rst_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (In_Byte)
            CMD_LOAD: begin
              state_d    = ST_LOAD;
              byte_cnt_d = 2'd0;
              wr_addr_d  = 8'd0;
            end
            CMD_RUN: begin
              state_d   = ST_RUN;
              pipe_en_d = 1'b1;
            end
            CMD_STEP: begin
              // The byte that enters STEP also issues the first step.
              state_d   = ST_STEP;
              pipe_en_d = 1'b1;
            end
            CMD_RESET: pipe_rst_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_LOAD: begin
        if (wr_en_q) begin
          // Write cycle just finished: advance the address unless at the top.
          if (wr_addr_q != LAST_ADDR) wr_addr_d = wr_addr_q + 8'd1;
          if ((wr_data_q == HALT_WORD) || (wr_addr_q == LAST_ADDR)) state_d = ST_IDLE;
        end else if (accept) begin
          word_d     = {word_q[15:0], In_Byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {word_q, In_Byte};
          end
        end
      end

      ST_RUN: begin
        if (Halt_WB) state_d = ST_DONE;
        else         pipe_en_d = 1'b1;
      end

      ST_STEP: begin
        if (pipe_en_q) begin
          // A step is completing; no byte can be accepted in this cycle.
          if (Halt_WB) state_d = ST_DONE;
        end else if (accept) begin
          if (In_Byte == CMD_STEP)      pipe_en_d = 1'b1;
          else if (In_Byte == CMD_QUIT) state_d   = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (accept && (In_Byte == CMD_RESET)) begin
          pipe_rst_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Bytes are refused while writing, stepping or running freely.
    in_ready_d = !(wr_en_d || pipe_en_d);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 2'd0;
      word_q     <= 24'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 32'd0;
      pipe_en_q  <= 1'b0;
      pipe_rst_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      pipe_en_q  <= pipe_en_d;
      pipe_rst_q <= pipe_rst_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign In_Ready    = in_ready_q;
  assign PipeEnable  = pipe_en_q;
  assign PipeReset   = pipe_rst_q;
  assign IMem_WrEn   = wr_en_q;
  assign IMem_WrAddr = wr_addr_q;
  assign IMem_WrData = wr_data_q;
  assign State_Out   = state_q;

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  // Count enabled pipeline cycles; cleared as a PipeReset pulse is issued
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (pipe_rst_d)     cyc_cnt_d = 32'd0;
    else if (pipe_en_q) cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  // Cycle counter register
  always_ff @(posedge Clock) begin
    if (Reset) cyc_cnt_q <= 32'd0;
    else       cyc_cnt_q <= cyc_cnt_d;
  end

  assign Cycle_Count = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb/tb_pipeline_debug_ctrl.sv - self-checking bench for pipeline_debug_ctrl
module tb_pipeline_debug_ctrl;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  In_Byte = 8'h00;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic        Halt_WB = 1'b0;
  logic        PipeEnable;
  logic        PipeReset;
  logic        IMem_WrEn;
  logic [7:0]  IMem_WrAddr;
  logic [31:0] IMem_WrData;
  logic [2:0]  State_Out;
`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] Cycle_Count;
`endif

  pipeline_debug_ctrl dut (
    .Clock       (clk),
    .Reset       (Reset),
    .In_Byte     (In_Byte),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .Halt_WB     (Halt_WB),
    .PipeEnable  (PipeEnable),
    .PipeReset   (PipeReset),
    .IMem_WrEn   (IMem_WrEn),
    .IMem_WrAddr (IMem_WrAddr),
    .IMem_WrData (IMem_WrData),
    .State_Out   (State_Out)
`ifdef DEBUG_CYCLE_COUNT_EN
    ,
    .Cycle_Count (Cycle_Count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] cmd;
    logic [2:0] exp_state;
    int         exp_pe;
    int         exp_pr;
  } vec_t;

  int  checks = 0;
  int  failures = 0;
  int  pe_cnt = 0;
  int  pr_cnt = 0;
  bit  mon_en = 1'b0;
  logic pr_prev = 1'b0;
  wr_t got_wr[$];
  wr_t exp_wr[$];

  int          m_state;
  int          m_addr;
  int          m_nb;
  logic [31:0] m_word;
  int          exp_pe;
  int          exp_pr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Observe every cycle: collect writes, count pulses, check invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      if (IMem_WrEn) begin
        wr_t w;
        w.addr = IMem_WrAddr;
        w.data = IMem_WrData;
        got_wr.push_back(w);
      end
      if (PipeEnable) pe_cnt++;
      if (PipeReset)  pr_cnt++;
      chk("inv_in_ready", {31'd0, In_Ready},
          {31'd0, !((State_Out == 3'd2) || IMem_WrEn || PipeEnable)});
      chk("inv_reset_with_enable", {31'd0, PipeReset && PipeEnable}, 32'd0);
      chk("inv_reset_width", {31'd0, PipeReset && pr_prev}, 32'd0);
      chk("inv_state_legal", {31'd0, State_Out <= 3'd4}, 32'd1);
      pr_prev = PipeReset;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    In_Valid = 1'b0;
    Reset    = 1'b1;
    @(negedge clk);
    Reset    = 1'b0;
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    In_Byte  = b;
    In_Valid = 1'b1;
    while (!In_Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, In_Ready}, 32'd1);
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_wr_count"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      chk({tag, "_wr_addr"}, {24'd0, got_wr[i].addr}, {24'd0, exp_wr[i].addr});
      chk({tag, "_wr_data"}, got_wr[i].data, exp_wr[i].data);
    end
  endtask

  // Byte-level reference: what each accepted byte means, independent of timing.
  task automatic model_byte(input logic [7:0] b);
    case (m_state)
      0: begin
        if (b == 8'h4C) begin m_state = 1; m_addr = 0; m_nb = 0; end
        else if (b == 8'h53) begin m_state = 3; exp_pe++; end
        else if (b == 8'h52) exp_pr++;
        else if (b == 8'h43) m_state = 2;
      end
      1: begin
        m_word = {m_word[23:0], b};
        m_nb++;
        if (m_nb == 4) begin
          push_exp(m_addr[7:0], m_word);
          m_nb = 0;
          if (m_word == 32'hFFFF_FFFF || m_addr == 255) m_state = 0;
          else m_addr++;
        end
      end
      3: begin
        if (b == 8'h53) exp_pe++;
        else if (b == 8'h51) m_state = 0;
      end
      4: begin
        if (b == 8'h52) begin exp_pr++; m_state = 0; end
      end
      default: ;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   pe0, pr0;
    logic [7:0] b;
    logic [7:0] pend[$];

    vecs[0] = '{cmd: 8'h52, exp_state: 3'd0, exp_pe: 0,  exp_pr: 1};
    vecs[1] = '{cmd: 8'h00, exp_state: 3'd0, exp_pe: 0,  exp_pr: 0};
    vecs[2] = '{cmd: 8'hFF, exp_state: 3'd0, exp_pe: 0,  exp_pr: 0};
    vecs[3] = '{cmd: 8'h51, exp_state: 3'd0, exp_pe: 0,  exp_pr: 0};
    vecs[4] = '{cmd: 8'h53, exp_state: 3'd3, exp_pe: 1,  exp_pr: 0};
    vecs[5] = '{cmd: 8'h4C, exp_state: 3'd1, exp_pe: 0,  exp_pr: 0};
    vecs[6] = '{cmd: 8'h43, exp_state: 3'd2, exp_pe: -1, exp_pr: 0};
    vecs[7] = '{cmd: 8'h6C, exp_state: 3'd0, exp_pe: 0,  exp_pr: 0};

    // Reset state
    do_reset();
    mon_en = 1'b1;
    chk("rst_state", {29'd0, State_Out}, 32'd0);
    chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
    chk("rst_pipe_en", {31'd0, PipeEnable}, 32'd0);
    chk("rst_pipe_rst", {31'd0, PipeReset}, 32'd0);
    chk("rst_wr_en", {31'd0, IMem_WrEn}, 32'd0);
    chk("rst_wr_addr", {24'd0, IMem_WrAddr}, 32'd0);
    chk("rst_wr_data", IMem_WrData, 32'd0);
`ifdef DEBUG_CYCLE_COUNT_EN
    chk("rst_cycle_count", Cycle_Count, 32'd0);
`endif

    // IDLE command decode table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      pe0 = pe_cnt;
      pr0 = pr_cnt;
      send_byte(vecs[i].cmd);
      wait_cycles(2);
      chk("vec_state", {29'd0, State_Out}, {29'd0, vecs[i].exp_state});
      if (vecs[i].exp_pe >= 0) chk("vec_pe_cycles", pe_cnt - pe0, vecs[i].exp_pe);
      chk("vec_pr_pulses", pr_cnt - pr0, vecs[i].exp_pr);
    end

    // Three-word load ending with the halt word
    do_reset();
    send_byte(8'h4C);
    send_word(32'h0000_0020);
    send_word(32'h8C01_0004);
    send_word(32'hFFFF_FFFF);
    wait_cycles(3);
    push_exp(8'd0, 32'h0000_0020);
    push_exp(8'd1, 32'h8C01_0004);
    push_exp(8'd2, 32'hFFFF_FFFF);
    compare_writes("load3");
    chk("load3_state", {29'd0, State_Out}, 32'd0);

    // Free run until Halt_WB, then leave DONE with 'R'
    do_reset();
    pe0 = pe_cnt;
    send_byte(8'h43);
    begin
      int n = 0;
      int k = 0;
      while (n < 10 && k < 100) begin
        @(negedge clk);
        if (PipeEnable) n++;
        k++;
      end
      Halt_WB = 1'b1;
      @(negedge clk);
      Halt_WB = 1'b0;
    end
    chk("run_pe_cycles", pe_cnt - pe0, 32'd10);
    chk("run_pe_low", {31'd0, PipeEnable}, 32'd0);
    chk("run_state_done", {29'd0, State_Out}, 32'd4);
`ifdef DEBUG_CYCLE_COUNT_EN
    chk("run_cycle_count", Cycle_Count, 32'd10);
`endif
    pr0 = pr_cnt;
    send_byte(8'h43);
    wait_cycles(2);
    chk("done_ignore_state", {29'd0, State_Out}, 32'd4);
    chk("done_ignore_pe", {31'd0, PipeEnable}, 32'd0);
    send_byte(8'h52);
    wait_cycles(2);
    chk("done_r_pulses", pr_cnt - pr0, 32'd1);
    chk("done_r_state", {29'd0, State_Out}, 32'd0);
`ifdef DEBUG_CYCLE_COUNT_EN
    chk("done_r_cycle_count", Cycle_Count, 32'd0);
`endif

    // Single stepping
    do_reset();
    pe0 = pe_cnt;
    send_byte(8'h53);
    send_byte(8'h53);
    send_byte(8'h53);
    send_byte(8'h51);
    wait_cycles(2);
    chk("step_pe_cycles", pe_cnt - pe0, 32'd3);
    chk("step_state", {29'd0, State_Out}, 32'd0);

    // Step that completes with Halt_WB high lands in DONE
    do_reset();
    pe0 = pe_cnt;
    Halt_WB = 1'b1;
    send_byte(8'h53);
    wait_cycles(2);
    Halt_WB = 1'b0;
    chk("step_halt_state", {29'd0, State_Out}, 32'd4);
    send_byte(8'h53);
    wait_cycles(2);
    chk("step_halt_pe", pe_cnt - pe0, 32'd1);
    chk("step_halt_still_done", {29'd0, State_Out}, 32'd4);

    // Reset in the middle of a word discards it
    do_reset();
    send_byte(8'h4C);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    wait_cycles(2);
    chk("midrst_no_write", got_wr.size(), 32'd0);
    chk("midrst_state", {29'd0, State_Out}, 32'd0);
    chk("midrst_addr", {24'd0, IMem_WrAddr}, 32'd0);
    send_byte(8'h4C);
    send_word(32'hDEAD_BEEF);
    send_word(32'hFFFF_FFFF);
    wait_cycles(3);
    push_exp(8'd0, 32'hDEAD_BEEF);
    push_exp(8'd1, 32'hFFFF_FFFF);
    compare_writes("midrst_reload");

    // Full 256-word load stops at the top address without wrapping
    do_reset();
    send_byte(8'h4C);
    for (int i = 0; i < 256; i++) begin
      send_word(32'h1000_0000 + i);
      push_exp(i[7:0], 32'h1000_0000 + i);
    end
    wait_cycles(3);
    chk("full_state", {29'd0, State_Out}, 32'd0);
    send_word(32'h1234_5678);
    wait_cycles(3);
    compare_writes("full");

    // Randomized byte stream against the byte-level reference
    do_reset();
    m_state = 0; m_addr = 0; m_nb = 0; m_word = 32'd0;
    exp_pe = 0; exp_pr = 0;
    pe0 = pe_cnt;
    pr0 = pr_cnt;
    for (int it = 0; it < 500; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (m_state == 1) begin
        if (pend.size() == 0) begin
          if (r < 3) for (int j = 0; j < 4; j++) pend.push_back(8'hFF);
          else for (int j = 0; j < 4; j++) pend.push_back(8'($urandom));
        end
        b = pend.pop_front();
      end else if (m_state == 3) begin
        if (r < 6)       b = 8'h53;
        else if (r == 6) b = 8'h51;
        else             b = 8'($urandom);
      end else begin
        if (r < 2)       b = 8'h4C;
        else if (r < 4)  b = 8'h53;
        else if (r == 4) b = 8'h52;
        else             b = 8'($urandom);
        if (b == 8'h43) b = 8'h00;
      end
      send_byte(b);
      model_byte(b);
    end
    wait_cycles(4);
    compare_writes("rand");
    chk("rand_pe_cycles", pe_cnt - pe0, exp_pe);
    chk("rand_pr_pulses", pr_cnt - pr0, exp_pr);
    chk("rand_state", {29'd0, State_Out}, m_state);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
